// File: rtl/step_map_manager_pkg.sv
// Shared tile types, map geometry and the constant level layouts.
package step_pkg;
  typedef logic [2:0] step_t;
  localparam step_t FREE = 3'b000;
  localparam step_t REGU = 3'b001;

  localparam int NUM_OF_ROWS = 7;
  localparam int NUM_OF_COLS = 10;
  localparam int NUM_LEVELS  = 2;
  localparam int CNT_W       = $clog2(NUM_OF_COLS + 1);

  // Element 0 of a row is column 0 and sits in the most significant slot.
  typedef step_t [0:NUM_OF_COLS-1] row_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam row_t LEVEL_ROM [NUM_LEVELS][NUM_OF_ROWS] = '{
    '{
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0},
      {3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1},
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0}
    },
    '{
      {3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
      {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3}
    }
  };

  function automatic cnt_t count_steps(input row_t r);
    cnt_t n;
    n = '0;
    for (int c = 0; c < NUM_OF_COLS; c++) begin
      if (r[c] != FREE) n = n + cnt_t'(1);
    end
    return n;
  endfunction
endpackage

// File: rtl/step_map_manager_if.sv
// Query / clear service slot between the game logic and the step map owner.
interface step_map_manager_if;
  import step_pkg::*;

  logic        q_req;
  logic [10:0] q_x;
  logic [10:0] q_y;
  logic        q_ack;
  step_t       q_step_type;

  logic        clr_req;
  logic [10:0] clr_x;
  logic [10:0] clr_y;
  logic        clr_ack;

  modport master (
    output q_req, q_x, q_y, clr_req, clr_x, clr_y,
    input  q_ack, q_step_type, clr_ack
  );

  modport slave (
    input  q_req, q_x, q_y, clr_req, clr_x, clr_y,
    output q_ack, q_step_type, clr_ack
  );
endinterface

// File: rtl/step_map_manager_level_rom.sv
// Combinational level ROM: one layout row plus its non-FREE tile count.
module step_level_rom
  import step_pkg::*;
#(
  parameter int LVL_W = 1,
  parameter int ROW_W = 3
) (
  input  logic [LVL_W-1:0] i_level,
  input  logic [ROW_W-1:0] i_row,
  output row_t             o_row,
  output cnt_t             o_count
);
  assign o_row   = LEVEL_ROM[i_level][i_row];
  assign o_count = count_steps(o_row);
endmodule

// File: rtl/step_map_manager.sv
// Owns the live step map: row-per-cycle level load, registered draw lookup
// and a single query/clear service slot where clears win over queries.
module step_map_manager #(
  parameter int NUM_OF_ROWS = step_pkg::NUM_OF_ROWS,
  parameter int NUM_OF_COLS = step_pkg::NUM_OF_COLS,
  parameter int TILE_SHIFT  = 6,
  parameter int NUM_LEVELS  = step_pkg::NUM_LEVELS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start_level,
  input  logic [$clog2(NUM_LEVELS)-1:0] level_sel,
  input  logic [10:0]                   pixelX,
  input  logic [10:0]                   pixelY,
  output step_pkg::step_t               step_type,
  output logic [10:0]                   tileTopLeftX,
  output logic [10:0]                   tileTopLeftY,
  step_map_manager_if.slave             bus,
  output logic                          busy,
  output logic [6:0]                    steps_left,
  output logic                          level_done
);
  import step_pkg::*;

  // state  | meaning
  // S_IDLE | no level loaded yet, requests held
  // S_LOAD | copying one ROM row per cycle, requests held
  // S_RUN  | level live, serving one query or clear per cycle
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam int ROW_W = $clog2(NUM_OF_ROWS);
  localparam int COL_W = $clog2(NUM_OF_COLS);
  localparam int LVL_W = $clog2(NUM_LEVELS);
  localparam logic [10:0]      ROWS_11  = 11'(NUM_OF_ROWS);
  localparam logic [10:0]      COLS_11  = 11'(NUM_OF_COLS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_OF_ROWS - 1);

  typedef row_t [NUM_OF_ROWS-1:0] map_t;

  logic [1:0]       r_state;
  logic [ROW_W-1:0] r_row;
  logic [LVL_W-1:0] r_level;
  map_t             r_map;
  step_t            r_step_type;
  step_t            r_q_type;
  logic [10:0]      r_tile_x;
  logic [10:0]      r_tile_y;
  logic             r_q_ack;
  logic             r_clr_ack;
  logic             r_done;
  logic [6:0]       r_steps;

  logic [10:0] w_px_col, w_px_row, w_q_col, w_q_row, w_clr_col, w_clr_row;
  step_t       w_px_type, w_q_type, w_clr_type;
  row_t        w_rom_row;
  cnt_t        w_rom_cnt;
  logic        w_clr_go, w_q_go;

  // Anything outside the grid reads as FREE, which also suppresses writes.
  function automatic step_t map_lookup(input map_t m, input logic [10:0] col,
                                       input logic [10:0] row);
    if (col >= COLS_11 || row >= ROWS_11) return FREE;
    return m[row[ROW_W-1:0]][col[COL_W-1:0]];
  endfunction

  assign w_px_col  = pixelX >> TILE_SHIFT;
  assign w_px_row  = pixelY >> TILE_SHIFT;
  assign w_q_col   = bus.q_x >> TILE_SHIFT;
  assign w_q_row   = bus.q_y >> TILE_SHIFT;
  assign w_clr_col = bus.clr_x >> TILE_SHIFT;
  assign w_clr_row = bus.clr_y >> TILE_SHIFT;

  assign w_px_type  = map_lookup(r_map, w_px_col, w_px_row);
  assign w_q_type   = map_lookup(r_map, w_q_col, w_q_row);
  assign w_clr_type = map_lookup(r_map, w_clr_col, w_clr_row);

  // A request still high in its own ack cycle is the one just served.
  assign w_clr_go = (r_state == S_RUN) && bus.clr_req && !r_clr_ack;
  assign w_q_go   = (r_state == S_RUN) && bus.q_req && !r_q_ack;

  step_level_rom #(
    .LVL_W (LVL_W),
    .ROW_W (ROW_W)
  ) u_rom (
    .i_level (r_level),
    .i_row   (r_row),
    .o_row   (w_rom_row),
    .o_count (w_rom_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_level     <= '0;
      r_map       <= '0;
      r_step_type <= FREE;
      r_q_type    <= FREE;
      r_tile_x    <= '0;
      r_tile_y    <= '0;
      r_q_ack     <= 1'b0;
      r_clr_ack   <= 1'b0;
      r_done      <= 1'b0;
      r_steps     <= '0;
    end else begin
      r_step_type <= w_px_type;
      r_tile_x    <= w_px_col << TILE_SHIFT;
      r_tile_y    <= w_px_row << TILE_SHIFT;
      r_q_ack     <= 1'b0;
      r_clr_ack   <= 1'b0;
      r_done      <= 1'b0;
      if (start_level) begin
        r_state <= S_LOAD;
        r_row   <= '0;
        r_level <= level_sel;
        r_steps <= '0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_map[r_row] <= w_rom_row;
            r_steps      <= r_steps + 7'(w_rom_cnt);
            if (r_row == LAST_ROW) r_state <= S_RUN;
            else                   r_row   <= r_row + 1'b1;
          end
          S_RUN: begin
            if (w_clr_go) begin
              r_clr_ack <= 1'b1;
              if (w_clr_type != FREE) begin
                r_map[w_clr_row[ROW_W-1:0]][w_clr_col[COL_W-1:0]] <= FREE;
                r_steps <= r_steps - 7'd1;
                r_done  <= (r_steps == 7'd1);
              end
            end else if (w_q_go) begin
              r_q_ack  <= 1'b1;
              r_q_type <= w_q_type;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign step_type       = r_step_type;
  assign tileTopLeftX    = r_tile_x;
  assign tileTopLeftY    = r_tile_y;
  assign bus.q_ack       = r_q_ack;
  assign bus.q_step_type = r_q_type;
  assign bus.clr_ack     = r_clr_ack;
  assign busy            = (r_state == S_LOAD);
  assign steps_left      = r_steps;
  assign level_done      = r_done;
endmodule

// File: tb/tb_step_map_manager.sv
// Self-checking bench for step_map_manager: table-driven draw/query vectors,
// ack scoreboard and hand-written load, priority, clear-all and reset sequences.
module tb_step_map_manager;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_level;
  logic [0:0]  level_sel;
  logic [10:0] pixelX, pixelY;
  logic [2:0]  step_type;
  logic [10:0] tileTopLeftX, tileTopLeftY;
  logic        busy;
  logic [6:0]  steps_left;
  logic        level_done;

  always #5 clk = ~clk;

  step_map_manager_if bus();

  step_map_manager dut (
    .clk          (clk),
    .reset        (reset),
    .start_level  (start_level),
    .level_sel    (level_sel),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .step_type    (step_type),
    .tileTopLeftX (tileTopLeftX),
    .tileTopLeftY (tileTopLeftY),
    .bus          (bus),
    .busy         (busy),
    .steps_left   (steps_left),
    .level_done   (level_done)
  );

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  typ;
    logic [10:0] tx;
    logic [10:0] ty;
  } vec_t;

  typedef struct {
    logic       done;
    logic [6:0] steps;
  } clr_exp_t;

  logic [2:0] q_exp [$];
  clr_exp_t   clr_exp [$];
  logic [2:0] e_q;
  clr_exp_t   e_c;
  int n_checks = 0;
  int n_errors = 0;

  vec_t draw_tab [7];
  vec_t q0_tab   [6];
  vec_t q1_tab   [4];
  int   regu_row [15];
  int   regu_col [15];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_clr(input logic done, input logic [6:0] steps);
    clr_exp_t ce;
    ce.done  = done;
    ce.steps = steps;
    clr_exp.push_back(ce);
  endtask

  // Scoreboard: every ack pops the oldest expectation for its channel.
  always @(negedge clk) begin
    if (bus.q_ack || bus.clr_ack)
      chk("single_ack", int'(bus.q_ack && bus.clr_ack), 0);
    if (bus.q_ack) begin
      if (q_exp.size() == 0) chk("q_ack_unexpected", q_exp.size(), 1);
      else begin
        e_q = q_exp.pop_front();
        chk("q_type", int'(bus.q_step_type), int'(e_q));
      end
    end
    if (bus.clr_ack) begin
      if (clr_exp.size() == 0) chk("clr_ack_unexpected", clr_exp.size(), 1);
      else begin
        e_c = clr_exp.pop_front();
        chk("clr_done", int'(level_done), int'(e_c.done));
        chk("clr_steps", int'(steps_left), int'(e_c.steps));
      end
    end
    if (level_done) chk("done_with_ack", int'(bus.clr_ack), 1);
  end

  task automatic load_level(input int lvl, input int exp_steps);
    level_sel   = 1'(lvl);
    start_level = 1'b1;
    cyc();
    start_level = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("busy_c%0d", i), int'(busy), (i <= 7) ? 1 : 0);
      if (i <= 7) chk("no_ack_busy", int'(bus.q_ack | bus.clr_ack), 0);
      if (i < 8) cyc();
    end
    chk("steps_at_run", int'(steps_left), exp_steps);
  endtask

  task automatic do_query(input logic [10:0] x, input logic [10:0] y,
                          input logic [2:0] exp, input string name);
    int lat;
    bus.q_x = x; bus.q_y = y; bus.q_req = 1'b1;
    q_exp.push_back(exp);
    lat = 0;
    do begin cyc(); lat++; end while (!bus.q_ack && lat < 20);
    chk({name, "_lat"}, lat, 1);
    bus.q_req = 1'b0;
    cyc();
  endtask

  task automatic do_clear(input logic [10:0] x, input logic [10:0] y,
                          input logic done, input logic [6:0] steps, input string name);
    int lat;
    bus.clr_x = x; bus.clr_y = y; bus.clr_req = 1'b1;
    push_clr(done, steps);
    lat = 0;
    do begin cyc(); lat++; end while (!bus.clr_ack && lat < 20);
    chk({name, "_lat"}, lat, 1);
    bus.clr_req = 1'b0;
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    draw_tab[0] = '{11'd0,   11'd64,  3'd1, 11'd0,   11'd64};
    draw_tab[1] = '{11'd10,  11'd10,  3'd0, 11'd0,   11'd0};
    draw_tab[2] = '{11'd130, 11'd130, 3'd1, 11'd128, 11'd128};
    draw_tab[3] = '{11'd639, 11'd479, 3'd0, 11'd576, 11'd448};
    draw_tab[4] = '{11'd600, 11'd300, 3'd1, 11'd576, 11'd256};
    draw_tab[5] = '{11'd640, 11'd0,   3'd0, 11'd640, 11'd0};
    draw_tab[6] = '{11'd500, 11'd200, 3'd1, 11'd448, 11'd192};
    q0_tab[0] = '{11'd130,  11'd130,  3'd1, 11'd0, 11'd0};
    q0_tab[1] = '{11'd700,  11'd100,  3'd0, 11'd0, 11'd0};
    q0_tab[2] = '{11'd64,   11'd447,  3'd1, 11'd0, 11'd0};
    q0_tab[3] = '{11'd300,  11'd300,  3'd0, 11'd0, 11'd0};
    q0_tab[4] = '{11'd2047, 11'd2047, 3'd0, 11'd0, 11'd0};
    q0_tab[5] = '{11'd575,  11'd447,  3'd1, 11'd0, 11'd0};
    q1_tab[0] = '{11'd0,    11'd0,    3'd2, 11'd0, 11'd0};
    q1_tab[1] = '{11'd639,  11'd447,  3'd3, 11'd0, 11'd0};
    q1_tab[2] = '{11'd64,   11'd64,   3'd0, 11'd0, 11'd0};
    q1_tab[3] = '{11'd0,    11'd64,   3'd0, 11'd0, 11'd0};
    regu_row = '{1, 1, 1, 2, 2, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};
    regu_col = '{0, 1, 2, 2, 3, 4, 5, 7, 8, 0, 9, 4, 5, 1, 8};

    reset = 1'b1; start_level = 1'b0; level_sel = 1'b0;
    pixelX = 11'd0; pixelY = 11'd0;
    bus.q_req = 1'b0; bus.q_x = 11'd0; bus.q_y = 11'd0;
    bus.clr_req = 1'b0; bus.clr_x = 11'd0; bus.clr_y = 11'd0;
    repeat (3) cyc();
    chk("rst_step_type", int'(step_type), 0);
    chk("rst_tile_x", int'(tileTopLeftX), 0);
    chk("rst_tile_y", int'(tileTopLeftY), 0);
    chk("rst_q_type", int'(bus.q_step_type), 0);
    chk("rst_q_ack", int'(bus.q_ack), 0);
    chk("rst_clr_ack", int'(bus.clr_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(level_done), 0);
    chk("rst_steps", int'(steps_left), 0);
    reset = 1'b0;
    pixelX = 11'd0; pixelY = 11'd64;
    cyc();
    chk("idle_map_free", int'(step_type), 0);
    chk("idle_busy", int'(busy), 0);

    load_level(0, 15);
    for (int i = 0; i < 7; i++) begin
      pixelX = draw_tab[i].x; pixelY = draw_tab[i].y;
      cyc();
      chk($sformatf("draw%0d_type", i), int'(step_type), int'(draw_tab[i].typ));
      chk($sformatf("draw%0d_tx", i), int'(tileTopLeftX), int'(draw_tab[i].tx));
      chk($sformatf("draw%0d_ty", i), int'(tileTopLeftY), int'(draw_tab[i].ty));
    end
    for (int i = 0; i < 6; i++)
      do_query(q0_tab[i].x, q0_tab[i].y, q0_tab[i].typ, $sformatf("q0_%0d", i));
    pixelX = 11'd130; pixelY = 11'd130;
    cyc();
    chk("draw_after_query", int'(step_type), 1);

    // Clear and query the same tile in the same cycle: clear goes first.
    bus.clr_x = 11'd0; bus.clr_y = 11'd64; bus.clr_req = 1'b1;
    bus.q_x   = 11'd0; bus.q_y   = 11'd64; bus.q_req   = 1'b1;
    push_clr(1'b0, 7'd14);
    q_exp.push_back(3'd0);
    cyc();
    chk("prio_clr_ack", int'(bus.clr_ack), 1);
    chk("prio_q_wait", int'(bus.q_ack), 0);
    chk("prio_steps", int'(steps_left), 14);
    bus.clr_req = 1'b0;
    cyc();
    chk("prio_q_ack", int'(bus.q_ack), 1);
    bus.q_req = 1'b0;
    cyc();

    // Held clear on a FREE tile: ack, ignored ack cycle, then a fresh ack.
    push_clr(1'b0, 7'd14);
    push_clr(1'b0, 7'd14);
    bus.clr_req = 1'b1;
    cyc(); chk("hold_ack1", int'(bus.clr_ack), 1);
    cyc(); chk("hold_ignored", int'(bus.clr_ack), 0);
    cyc(); chk("hold_ack2", int'(bus.clr_ack), 1);
    bus.clr_req = 1'b0;
    cyc();

    for (int i = 1; i < 15; i++)
      do_clear(11'(regu_col[i] * 64 + 5), 11'(regu_row[i] * 64 + 7),
               (i == 14), 7'(14 - i), $sformatf("clr_%0d", i));
    chk("done_is_pulse", int'(level_done), 0);
    chk("all_cleared", int'(steps_left), 0);
    do_clear(11'd520, 11'd400, 1'b0, 7'd0, "clr_repeat");
    pixelX = 11'd130; pixelY = 11'd130;
    cyc();
    chk("draw_cleared", int'(step_type), 0);

    // Load level 1 while a clear is pending: the clear lands on the new map.
    bus.clr_x = 11'd3; bus.clr_y = 11'd70; bus.clr_req = 1'b1;
    push_clr(1'b0, 7'd5);
    load_level(1, 6);
    chk("pend_clr_not_yet", int'(bus.clr_ack), 0);
    lat = 0;
    do begin cyc(); lat++; end while (!bus.clr_ack && lat < 20);
    chk("pend_clr_lat", lat, 1);
    bus.clr_req = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++)
      do_query(q1_tab[i].x, q1_tab[i].y, q1_tab[i].typ, $sformatf("q1_%0d", i));

    // Reset in the middle of a load, with a query raised just before it.
    pixelX = 11'd130; pixelY = 11'd130;
    level_sel = 1'b0; start_level = 1'b1;
    cyc();
    start_level = 1'b0;
    cyc(); cyc(); cyc();
    reset = 1'b1;
    bus.q_x = 11'd130; bus.q_y = 11'd130; bus.q_req = 1'b1;
    q_exp.push_back(3'd1);
    cyc();
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_steps", int'(steps_left), 0);
    reset = 1'b0;
    cyc();
    chk("mid_rst_map_free", int'(step_type), 0);
    for (int i = 0; i < 4; i++) begin
      chk("held_q_idle", int'(bus.q_ack), 0);
      cyc();
    end
    load_level(0, 15);
    lat = 0;
    do begin cyc(); lat++; end while (!bus.q_ack && lat < 20);
    chk("held_q_lat", lat, 1);
    bus.q_req = 1'b0;
    cyc();

    chk("q_queue_empty", q_exp.size(), 0);
    chk("clr_queue_empty", clr_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/step_map_manager.md
# step_map_manager

Owns the live Bumpy step map as a register array and sequences every access to it. On request it loads a level layout row by row from a constant level ROM. It then serves the VGA draw lookup every cycle and arbitrates a single modify/query slot between the game logic's collision queries and step-clear requests. It sits between the level/game FSM, the ball collision logic and the step drawing object.

## Interface
Parameters:
- NUM_OF_ROWS, 7, map rows
- NUM_OF_COLS, 10, map columns
- TILE_SHIFT, 6, log2 of tile edge in pixels (64)
- NUM_LEVELS, 2, layouts in the level ROM

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start_level  in  1  one-cycle pulse: load level_sel
- level_sel  in  $clog2(NUM_LEVELS)  level index, sampled with start_level
- pixelX, pixelY  in  11 each  current VGA pixel
- step_type  out  3  tile type under pixel
- tileTopLeftX, tileTopLeftY  out  11 each  tile origin under pixel
- q_req  in  1  collision query request
- q_x, q_y  in  11 each  query pixel coordinates
- q_ack  out  1  one-cycle query acknowledge
- q_step_type  out  3  query result, valid with q_ack
- clr_req  in  1  step-clear request
- clr_x, clr_y  in  11 each  pixel coordinates of the tile to clear
- clr_ack  out  1  one-cycle clear acknowledge
- busy  out  1  high while loading
- steps_left  out  7  count of non-FREE tiles
- level_done  out  1  one-cycle pulse when steps_left reaches 0 by a clear

## Operation
- Tile encoding: FREE=3'b000, REGU=3'b001. All other codes count as non-FREE.
- Index computation: col = x >> TILE_SHIFT, row = y >> TILE_SHIFT.
- Out-of-grid rule: col >= NUM_OF_COLS or row >= NUM_OF_ROWS reads as FREE, and writes are ignored.
- FSM states: IDLE -> LOAD on start_level. LOAD -> RUN after the last row. RUN -> LOAD on start_level.
- reset forces IDLE from any state, including mid-LOAD.
- LOAD:
  - One row is copied from the ROM per cycle, row 0 first.
  - steps_left is cleared on entry, then increased by each row's non-FREE count.
- Draw path: active in every state, no arbitration. It reads the map as currently written.
- Arbitration (RUN only):
  - At most one of q_ack or clr_ack is asserted per cycle.
  - clr_req has priority over q_req.
  - Requesters hold req and operands stable until ack.
  - A req that is high in its own ack cycle is ignored. It is a new request only from the next cycle.
- Query: returns the tile type at (q_x, q_y). The map is unchanged.
- Clear:
  - If the tile is non-FREE: write FREE and decrement steps_left.
  - If steps_left goes 1 -> 0: pulse level_done together with clr_ack.
  - Clearing a FREE or out-of-grid tile still acks, with no change.
- In IDLE and LOAD, requests are held pending, not acked.
- start_level in RUN together with a pending clr_req: the load wins. The clear is served in RUN against the new map.
- start_level during LOAD restarts the load from row 0 with the new level_sel.

## Timing
- Reset values:
  - map all FREE; state IDLE.
  - step_type, tileTopLeftX, tileTopLeftY, q_step_type = 0.
  - q_ack, clr_ack, busy, level_done = 0; steps_left = 0.
- Draw latency: 1 cycle, registered. Outputs at N+1 reflect pixelX/pixelY and the map contents at N.
- tileTopLeftX/Y = index << TILE_SHIFT.
- Load, with start_level at cycle N:
  - busy is high N+1..N+NUM_OF_ROWS.
  - Row r is written at the edge ending cycle N+1+r.
  - RUN from N+NUM_OF_ROWS+1. steps_left is final at that cycle.
- Request service: a req sampled in RUN at cycle N gives ack and data at N+1 (registered). A clear's map write and steps_left update are visible at N+1.
- Worst-case query wait: 2 cycles with back-to-back clears (one clear per 2 cycles due to the ack-cycle rule).

## Structure
- Package step_pkg holds:
  - step_t (3-bit) and the FREE/REGU constants.
  - NUM_OF_ROWS and NUM_OF_COLS.
  - The constant level layouts, indexed [level][row][col].
- Sub-module step_level_rom:
  - Inputs: level and row index.
  - Outputs: a combinational row vector and that row's non-FREE count.
- The FSM, arbiter, map registers and draw path live in step_map_manager.

## Test plan
- Reset then level 0 load: busy high exactly 7 cycles. steps_left = 15 at RUN. Draw at pixel (0,64) gives step_type=1 and tile origin (0,64) one cycle later.
- Query at (130,130), then at (700,100): q_ack after 1 cycle with q_step_type=1, then 0 (out of grid). Map unchanged.
- Same-cycle clr_req (0,64) and q_req (0,64): clr_ack first. q_ack one cycle later returns 0. steps_left drops 15 -> 14.
- Clear all 15 REGU tiles of level 0: last clr_ack coincides with level_done=1 and steps_left=0. A repeat clear acks with no pulse.
- start_level on level 1 at the same cycle as a pending clr_req: the clear is not acked during busy, then acked against the level 1 map.
- reset asserted at LOAD row 3: next cycle state IDLE, map all FREE, busy=0, steps_left=0. Held requests are not acked until a new load completes.
